fatori_scrub_sched: RTL and testbench

Scrub scheduler for the M-of-N protected register groups of the Fatori-hardened Ibex. It decides which register group is refreshed next and when. Groups with a pending minor error are served first, round-robin among themselves; otherwise groups are swept round-robin at a programmable interval. Each scrub is one request/acknowledge exchange. Every completed scrub produces a one-cycle pulse, which the fault manager's correction counter consumes. An acknowledge timeout produces a timeout pulse, which the fault manager treats as a major event.

---
 rtl/fatori_pkg.sv | 14 +
 rtl/fatori_rr_arb.sv | 30 +++
 rtl/fatori_scrub_sched.sv | 166 ++++++++++++++++
 tb/tb_fatori_scrub_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fatori_pkg.sv
// Shared types and widths for the Fatori scrub scheduler.
// Holds the scheduler FSM state encoding and counter/interval widths.
package fatori_pkg;

   localparam int unsigned SCRUB_CNT_W = 16;
   localparam int unsigned INTERVAL_W  = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      REQ    = 2'd2
   } scrub_state_e;

endpackage

// File: rtl/fatori_rr_arb.sv
// Combinational masked round-robin picker.
// Ports: req_i request vector, ptr_i last winner; idx_o first set bit
// searching upward from ptr_i+1 (mod N), valid_o high if any bit set.
module fatori_rr_arb #(
   parameter int unsigned N     = 8,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   int j;

   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      j       = 0;
      // i runs 1..N so the pointer itself is checked last
      for (int i = 1; i <= int'(N); i++) begin
         j = (int'(ptr_i) + i) % int'(N);
         if (!valid_o && req_i[j]) begin
            valid_o = 1'b1;
            idx_o   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/fatori_scrub_sched.sv
// Scrub scheduler: error-flagged groups first (round-robin), else a
// periodic round-robin sweep, one req/ack exchange per scrub.
// Ports: clk_i, rst_ni, enable_i, interval_i, err_flag_i, scrub_ack_i in;
// scrub_req_o, scrub_occurred_o, timeout_o, busy_o, last_group_o,
// scrub_cnt_o out. Macro FATORI_SCRUB_TIMEOUT_EN adds the ack timeout.
module fatori_scrub_sched
   import fatori_pkg::*;
#(
   parameter int unsigned NGROUPS        = 8,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   localparam int unsigned IDX_W         = $clog2(NGROUPS)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   enable_i,
   input  logic [INTERVAL_W-1:0]  interval_i,
   input  logic [NGROUPS-1:0]     err_flag_i,
   input  logic [NGROUPS-1:0]     scrub_ack_i,
   output logic [NGROUPS-1:0]     scrub_req_o,
   output logic                   scrub_occurred_o,
   output logic                   timeout_o,
   output logic                   busy_o,
   output logic [IDX_W-1:0]       last_group_o,
   output logic [SCRUB_CNT_W-1:0] scrub_cnt_o
);

   if (NGROUPS < 2 || NGROUPS > 32 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("fatori_scrub_sched: parameter out of range");
   end

   scrub_state_e           state_q, state_d;
   logic [INTERVAL_W-1:0]  icnt_q, icnt_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic                   occ_q, occ_d;
   logic                   to_q, to_d;
   logic [SCRUB_CNT_W-1:0] cnt_q, cnt_d;

   logic [IDX_W-1:0] err_idx, per_idx;
   logic             err_vld, per_vld;
   logic             ack_hit, tmo_hit, settle, per_due;

   fatori_rr_arb #(.N(NGROUPS), .IDX_W(IDX_W)) u_err_arb (
      .req_i   (err_flag_i),
      .ptr_i   (ptr_q),
      .idx_o   (err_idx),
      .valid_o (err_vld)
   );

   fatori_rr_arb #(.N(NGROUPS), .IDX_W(IDX_W)) u_per_arb (
      .req_i   ({NGROUPS{1'b1}}),
      .ptr_i   (ptr_q),
      .idx_o   (per_idx),
      .valid_o (per_vld)
   );

   assign ack_hit = scrub_ack_i[grant_q];

   // The IDLE cycle carrying the completion pulse is not counted, so
   // back-to-back periodic requests sit interval_i+3 cycles apart.
   assign settle  = occ_q | to_q;
   assign per_due = !settle && (interval_i != '0)
                    && (icnt_q == interval_i - INTERVAL_W'(1));

`ifdef FATORI_SCRUB_TIMEOUT_EN
   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES);
   logic [WAIT_W-1:0] wait_q, wait_d;

   assign tmo_hit = (state_q == REQ)
                    && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wait_d = '0;
      if (state_q == REQ && !ack_hit && !tmo_hit) begin
         wait_d = wait_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) wait_q <= '0;
      else         wait_q <= wait_d;
   end

   assign timeout_o = to_q;
`else
   assign tmo_hit   = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      icnt_d  = icnt_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      last_d  = last_q;
      occ_d   = 1'b0;
      to_d    = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            icnt_d = '0;
            if (enable_i) begin
               if ((|err_flag_i) || per_due) begin
                  state_d = SELECT;
               end else if (!settle) begin
                  icnt_d = icnt_q + INTERVAL_W'(1);
               end
            end
         end
         SELECT: begin
            icnt_d = '0;
            if (err_vld)      grant_d = err_idx;
            else if (per_vld) grant_d = per_idx;
            ptr_d   = grant_d;
            last_d  = grant_d;
            state_d = REQ;
         end
         REQ: begin
            icnt_d = '0;
            if (ack_hit) begin
               occ_d   = 1'b1;
               cnt_d   = cnt_q + SCRUB_CNT_W'(1);
               state_d = IDLE;
            end else if (tmo_hit) begin
               to_d    = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            icnt_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         icnt_q  <= '0;
         ptr_q   <= IDX_W'(NGROUPS - 1);
         grant_q <= '0;
         last_q  <= '0;
         occ_q   <= 1'b0;
         to_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         icnt_q  <= icnt_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         occ_q   <= occ_d;
         to_q    <= to_d;
         cnt_q   <= cnt_d;
      end
   end

   assign scrub_req_o      = (state_q == REQ) ? (NGROUPS'(1) << grant_q)
                                              : '0;
   assign scrub_occurred_o = occ_q;
   assign busy_o           = (state_q != IDLE);
   assign last_group_o     = last_q;
   assign scrub_cnt_o      = cnt_q;

endmodule

// File: tb/tb_fatori_scrub_sched.sv
// Directed bench for fatori_scrub_sched (NGROUPS=8, TIMEOUT_CYCLES=64).
// Checks reset, periodic sweep, error priority, timeout/hold, wrap, reset.
module tb_fatori_scrub_sched;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        enable_i;
   logic [15:0] interval_i;
   logic [7:0]  err_flag_i;
   logic [7:0]  scrub_ack_i;
   logic [7:0]  scrub_req_o;
   logic        occ;
   logic        tmo;
   logic        busy;
   logic [2:0]  last;
   logic [15:0] cnt;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] exp_cnt = '0;

   always #5 clk = ~clk;

   fatori_scrub_sched #(.NGROUPS(8), .TIMEOUT_CYCLES(64)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .enable_i         (enable_i),
      .interval_i       (interval_i),
      .err_flag_i       (err_flag_i),
      .scrub_ack_i      (scrub_ack_i),
      .scrub_req_o      (scrub_req_o),
      .scrub_occurred_o (occ),
      .timeout_o        (tmo),
      .busy_o           (busy),
      .last_group_o     (last),
      .scrub_cnt_o      (cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(string tag, int g, int exp_n);
      int          k;
      logic [7:0]  oh;
      k  = 0;
      oh = 8'd1 << g;
      while (scrub_req_o == 8'h00 && k < 2000) begin
         tick();
         k++;
      end
      chk({tag, "_req"}, 32'(scrub_req_o), 32'(oh));
      chk({tag, "_lat"}, 32'(k), 32'(exp_n));
   endtask

   task automatic do_ack(string tag, int g);
      scrub_ack_i = 8'd1 << g;
      tick();
      scrub_ack_i = 8'h00;
      exp_cnt     = exp_cnt + 16'd1;
      chk({tag, "_occ"}, 32'(occ), 32'd1);
      chk({tag, "_reqoff"}, 32'(scrub_req_o), 32'd0);
      chk({tag, "_cnt"}, 32'(cnt), 32'(exp_cnt));
   endtask

   initial begin
      int k;
      rst_ni      = 1'b0;
      enable_i    = 1'b0;
      interval_i  = 16'd10;
      err_flag_i  = 8'h00;
      scrub_ack_i = 8'h00;
      tick();
      tick();
      chk("rst_req", 32'(scrub_req_o), 32'd0);
      chk("rst_occ", 32'(occ), 32'd0);
      chk("rst_to", 32'(tmo), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_last", 32'(last), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_ptr", 32'(dut.ptr_q), 32'd7);

      // periodic sweep, interval 10, immediate ack
      rst_ni   = 1'b1;
      enable_i = 1'b1;
      wait_req("p0", 0, 11);
      do_ack("a0", 0);
      tick();
      chk("occ_width", 32'(occ), 32'd0);
      wait_req("p1", 1, 11);
      do_ack("a1", 1);

      // error flags on groups 2 and 5, pointer now 1
      err_flag_i = 8'b0010_0100;
      tick();
      chk("e_sel_busy", 32'(busy), 32'd1);
      chk("e_sel_req", 32'(scrub_req_o), 32'd0);
      tick();
      chk("e2_req", 32'(scrub_req_o), 32'h04);
      chk("e2_last", 32'(last), 32'd2);
      err_flag_i = 8'b0010_0000;
      do_ack("a2", 2);
      chk("cnt3", 32'(cnt), 32'd3);
      wait_req("e5", 5, 2);
      err_flag_i = 8'h00;
      do_ack("a5", 5);
      wait_req("p6", 6, 12);

      // ack on a non-granted bit is ignored
      scrub_ack_i = 8'h08;
      tick();
      scrub_ack_i = 8'h00;
      chk("wrong_req", 32'(scrub_req_o), 32'h40);
      chk("wrong_occ", 32'(occ), 32'd0);
      do_ack("a6", 6);
      wait_req("p7", 7, 12);

`ifdef FATORI_SCRUB_TIMEOUT_EN
      k = 0;
      while (!tmo && k < 200) begin
         tick();
         k++;
      end
      chk("tmo_lat", 32'(k), 32'd64);
      chk("tmo_req", 32'(scrub_req_o), 32'd0);
      chk("tmo_occ", 32'(occ), 32'd0);
      chk("tmo_cnt", 32'(cnt), 32'(exp_cnt));
      tick();
      chk("tmo_width", 32'(tmo), 32'd0);
`else
      repeat (1000) tick();
      chk("hold_req", 32'(scrub_req_o), 32'h80);
      chk("hold_to", 32'(tmo), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
      do_ack("a7", 7);
      tick();
`endif
      wait_req("p0b", 0, 11);

      // ack arrives in the cycle the timeout would fire
      repeat (63) tick();
      do_ack("race", 0);
      chk("race_to", 32'(tmo), 32'd0);

      // counter wrap from FFFF
      enable_i = 1'b0;
      tick();
      force dut.cnt_q = 16'hFFFF;
      tick();
      release dut.cnt_q;
      chk("force_cnt", 32'(cnt), 32'h0000_FFFF);
      exp_cnt  = 16'hFFFF;
      enable_i = 1'b1;
      wait_req("p1b", 1, 11);
      do_ack("wrap", 1);
      chk("wrap_zero", 32'(cnt), 32'd0);
      wait_req("p2b", 2, 12);

      // asynchronous reset in REQ
      rst_ni = 1'b0;
      #1;
      chk("arst_req", 32'(scrub_req_o), 32'd0);
      chk("arst_occ", 32'(occ), 32'd0);
      chk("arst_to", 32'(tmo), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      enable_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      repeat (30) tick();
      chk("dis_busy", 32'(busy), 32'd0);
      chk("dis_req", 32'(scrub_req_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
